counter_prog: RTL



---
 rtl/counter_pkg.sv | 19 +
 rtl/prescaler.sv | 32 +++
 rtl/counter_prog.sv | 97 +++++++++
 3 files changed

// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants, types and helpers for counter_prog
package counter_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    typedef logic [1:0] sel_t;

    localparam int DEFAULT_LIMIT0 = 5;
    localparam int DEFAULT_LIMIT1 = 15;
    localparam int DEFAULT_LIMIT2 = 63;
    localparam int DEFAULT_LIMIT3 = 255;

    // Prescaler register width: never narrower than one bit, even for N_PRESCALE=1.
    function automatic int prescale_width(input int n_prescale);
        return (n_prescale <= 2) ? 1 : $clog2(n_prescale);
    endfunction

endpackage

// File: rtl/prescaler.sv
// rtl/prescaler.sv - valid-gated modulo-N_PRESCALE prescaler producing a step strobe
module prescaler
    import counter_pkg::*;
#(
    parameter int N_PRESCALE = 1
) (
    input  logic i_clock,
    input  logic i_reset,
    input  logic i_valid,
    input  logic i_clear,
    output logic o_step
);

    localparam int             PW   = prescale_width(N_PRESCALE);
    localparam logic [PW-1:0]  LAST = PW'(N_PRESCALE - 1);

    logic [PW-1:0] count;

    // Gaps in i_valid stall the count rather than restarting it.
    assign o_step = i_valid && (count == LAST);

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            count <= '0;
        end else if (i_clear) begin
            count <= '0;
        end else if (i_valid) begin
            count <= o_step ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/counter_prog.sv
// rtl/counter_prog.sv - up/down counter with selectable terminal value and tick pulse
// Define COUNTER_PROG_SATURATE_EN to stop at the terminal value instead of wrapping.
module counter_prog
    import counter_pkg::*;
#(
    parameter int NB_COUNT   = 8,
    parameter int N_PRESCALE = 1,
    parameter int LIMIT0     = DEFAULT_LIMIT0,
    parameter int LIMIT1     = DEFAULT_LIMIT1,
    parameter int LIMIT2     = DEFAULT_LIMIT2,
    parameter int LIMIT3     = DEFAULT_LIMIT3
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic                i_clear,
    input  sel_t                i_sel,
    input  logic                i_dir,
    output logic [NB_COUNT-1:0] o_count,
    output logic                o_tick
);

    logic                step;
    logic [NB_COUNT-1:0] limit;
    logic [NB_COUNT-1:0] count_next;
    logic                tick_next;

    prescaler #(
        .N_PRESCALE(N_PRESCALE)
    ) u_prescaler (
        .i_clock(i_clock),
        .i_reset(i_reset),
        .i_valid(i_valid),
        .i_clear(i_clear),
        .o_step (step)
    );

    always_comb begin
        case (i_sel)
            2'd0:    limit = NB_COUNT'(LIMIT0);
            2'd1:    limit = NB_COUNT'(LIMIT1);
            2'd2:    limit = NB_COUNT'(LIMIT2);
            default: limit = NB_COUNT'(LIMIT3);
        endcase
    end

    always_comb begin
        count_next = o_count;
        tick_next  = 1'b0;
        if (step) begin
            if (i_dir == DIR_UP) begin
                if (o_count < limit) begin
                    count_next = o_count + 1'b1;
`ifdef COUNTER_PROG_SATURATE_EN
                    tick_next  = (o_count + 1'b1 == limit);
`endif
                end else begin
`ifdef COUNTER_PROG_SATURATE_EN
                    count_next = limit;
`else
                    count_next = '0;
                    tick_next  = 1'b1;
`endif
                end
            end else begin
                // A count left above a freshly reduced limit is pulled down silently.
                if (o_count > limit) begin
                    count_next = limit;
                end else if (o_count == '0) begin
`ifndef COUNTER_PROG_SATURATE_EN
                    count_next = limit;
                    tick_next  = 1'b1;
`endif
                end else begin
                    count_next = o_count - 1'b1;
`ifdef COUNTER_PROG_SATURATE_EN
                    tick_next  = (o_count == NB_COUNT'(1));
`endif
                end
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_count <= '0;
            o_tick  <= 1'b0;
        end else if (i_clear) begin
            o_count <= '0;
            o_tick  <= 1'b0;
        end else begin
            o_count <= count_next;
            o_tick  <= tick_next;
        end
    end

endmodule
